// File: rtl/servo_cmd_parser_if.sv
// Command-parser bus: received byte stream in, decoded servo command and
// error strobes out. master = parser side, slave = byte source / command sink.
// Ports: RxData/RxDone (byte in), cmd_* (good frame), frame_err/err_code, busy.
interface servo_cmd_parser_if #(
  parameter int CH_W = 2
);
  logic [7:0]      RxData;
  logic            RxDone;
  logic            cmd_valid;
  logic [CH_W-1:0] cmd_channel;
  logic [15:0]     cmd_pos_us;
  logic            cmd_clamped;
  logic            frame_err;
  logic [1:0]      err_code;
  logic            busy;

  modport master (
    input  RxData, RxDone,
    output cmd_valid, cmd_channel, cmd_pos_us, cmd_clamped,
    output frame_err, err_code, busy
  );

  modport slave (
    output RxData, RxDone,
    input  cmd_valid, cmd_channel, cmd_pos_us, cmd_clamped,
    input  frame_err, err_code, busy
  );
endinterface

// File: rtl/servo_cmd_parser.sv
// Servo command parser: assembles SYNC,chan,pos_hi,pos_lo,csum frames from UART
// bytes, validates channel/checksum, clamps pulse width, strobes cmd_valid.
// Latency: cmd_valid / frame_err 3 cycles after RxDone is first sampled high on
// the last byte. No backpressure: every byte is consumed, strobes are one cycle.
// Ports: Clk, Rst (async, active-high), bus (servo_cmd_parser_if.master).
module servo_cmd_parser #(
  parameter int         NUM_CH      = 4,
  parameter int         CH_W        = 2,
  parameter int         MIN_US      = 500,
  parameter int         MAX_US      = 2500,
  parameter int         TIMEOUT_CYC = 500000,
  parameter logic [7:0] SYNC_BYTE   = 8'hFF
) (
  input  logic              Clk,
  input  logic              Rst,
  servo_cmd_parser_if.master bus
);

  localparam int          TW       = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYC - 1);
  localparam logic [15:0] MIN16    = 16'(MIN_US);
  localparam logic [15:0] MAX16    = 16'(MAX_US);

  localparam logic [1:0] ERR_CHAN = 2'd1;
  localparam logic [1:0] ERR_CSUM = 2'd2;
  localparam logic [1:0] ERR_TMO  = 2'd3;

  typedef enum logic [2:0] {
    HUNT,
    CHAN,
    POSH,
    POSL,
    CSUM
  } state_t;

  state_t          state;
  logic [2:0]      sync_q;     // [0]=s1, [1]=s2, [2]=s3
  logic [7:0]      acc;
  logic [CH_W-1:0] chan_q;
  logic [7:0]      pos_hi_q;
  logic [7:0]      pos_lo_q;
  logic [TW-1:0]   tmo_cnt;

  logic            cmd_valid_q;
  logic [CH_W-1:0] cmd_channel_q;
  logic [15:0]     cmd_pos_q;
  logic            cmd_clamped_q;
  logic            frame_err_q;
  logic [1:0]      err_code_q;

  logic            byte_stb;
  logic [7:0]      rx_byte;
  logic [15:0]     pos_raw;
  logic [TW-1:0]   tmo_inc;
  logic            chan_bad;

  // Rising edge of the synchronised RxDone: one byte per pulse, whatever its length.
  assign byte_stb = sync_q[1] & ~sync_q[2];
  assign rx_byte  = bus.RxData;
  assign pos_raw  = {pos_hi_q, pos_lo_q};
  assign tmo_inc  = tmo_cnt + 1'b1;
  assign chan_bad = ({24'd0, rx_byte} >= 32'(NUM_CH));

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state         <= HUNT;
      sync_q        <= 3'b000;
      acc           <= 8'h00;
      chan_q        <= '0;
      pos_hi_q      <= 8'h00;
      pos_lo_q      <= 8'h00;
      tmo_cnt       <= '0;
      cmd_valid_q   <= 1'b0;
      cmd_channel_q <= '0;
      cmd_pos_q     <= 16'h0000;
      cmd_clamped_q <= 1'b0;
      frame_err_q   <= 1'b0;
      err_code_q    <= 2'd0;
    end else begin
      sync_q      <= {sync_q[1:0], bus.RxDone};
      cmd_valid_q <= 1'b0;
      frame_err_q <= 1'b0;

      if (byte_stb) begin
        // A byte arriving in the expiry cycle takes priority over the timeout.
        tmo_cnt <= '0;
        case (state)
          HUNT: begin
            if (rx_byte == SYNC_BYTE) state <= CHAN;
          end
          CHAN: begin
            if (rx_byte == SYNC_BYTE) begin
              state <= CHAN;  // repeated sync: restart the frame silently
            end else if (chan_bad) begin
              frame_err_q <= 1'b1;
              err_code_q  <= ERR_CHAN;
              state       <= HUNT;
            end else begin
              chan_q <= rx_byte[CH_W-1:0];
              acc    <= rx_byte;
              state  <= POSH;
            end
          end
          POSH: begin
            pos_hi_q <= rx_byte;
            acc      <= acc ^ rx_byte;
            state    <= POSL;
          end
          POSL: begin
            pos_lo_q <= rx_byte;
            acc      <= acc ^ rx_byte;
            state    <= CSUM;
          end
          CSUM: begin
            if (rx_byte == acc) begin
              cmd_valid_q   <= 1'b1;
              cmd_channel_q <= chan_q;
              if (pos_raw < MIN16) begin
                cmd_pos_q     <= MIN16;
                cmd_clamped_q <= 1'b1;
              end else if (pos_raw > MAX16) begin
                cmd_pos_q     <= MAX16;
                cmd_clamped_q <= 1'b1;
              end else begin
                cmd_pos_q     <= pos_raw;
                cmd_clamped_q <= 1'b0;
              end
            end else begin
              frame_err_q <= 1'b1;
              err_code_q  <= ERR_CSUM;
            end
            state <= HUNT;
          end
          default: state <= HUNT;
        endcase
      end else if (state == HUNT) begin
        tmo_cnt <= '0;
      end else if (tmo_inc == TMO_LAST) begin
        // The count reaches TIMEOUT_CYC-1 on this edge: abandon the frame now,
        // so the error strobe lands TIMEOUT_CYC cycles after the last byte strobe.
        frame_err_q <= 1'b1;
        err_code_q  <= ERR_TMO;
        state       <= HUNT;
        tmo_cnt     <= '0;
      end else begin
        tmo_cnt <= tmo_inc;
      end
    end
  end

  assign bus.cmd_valid   = cmd_valid_q;
  assign bus.cmd_channel = cmd_channel_q;
  assign bus.cmd_pos_us  = cmd_pos_q;
  assign bus.cmd_clamped = cmd_clamped_q;
  assign bus.frame_err   = frame_err_q;
  assign bus.err_code    = err_code_q;
  assign bus.busy        = (state != HUNT);

endmodule

// File: tb/tb_servo_cmd_parser.sv
module tb_servo_cmd_parser;

  logic   clk;
  logic   rst;
  longint cyc;

  servo_cmd_parser_if #(.CH_W(2)) bus ();

  servo_cmd_parser #(
    .NUM_CH(4), .CH_W(2), .MIN_US(500), .MAX_US(2500),
    .TIMEOUT_CYC(100), .SYNC_BYTE(8'hFF)
  ) dut (
    .Clk(clk),
    .Rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc++;

  typedef struct {
    bit     is_err;
    int     ch;
    int     pos;
    int     clamped;
    int     code;
    longint at;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string name, input longint act, input longint req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Drive one byte; if push is set, queue the expected strobe lat cycles after the rise.
  task automatic send_byte(input logic [7:0] b, input int hi, input int lo,
                           input bit push, input exp_t e, input int lat);
    @(negedge clk);
    bus.RxData = b;
    bus.RxDone = 1'b1;
    if (push) begin
      e.at = cyc + lat;
      exp_q.push_back(e);
    end
    repeat (hi) @(negedge clk);
    bus.RxDone = 1'b0;
    repeat (lo) @(negedge clk);
  endtask

  task automatic frame5(input logic [7:0] c, input logic [7:0] ph, input logic [7:0] pl,
                        input logic [7:0] cs, input int hi, input int lo,
                        input bit is_err, input int ech, input int epos,
                        input int ecl, input int ecode);
    exp_t e;
    e = '{is_err, ech, epos, ecl, ecode, 0};
    send_byte(8'hFF, hi, lo, 1'b0, e, 0);
    send_byte(c,     hi, lo, 1'b0, e, 0);
    send_byte(ph,    hi, lo, 1'b0, e, 0);
    send_byte(pl,    hi, lo, 1'b0, e, 0);
    send_byte(cs,    hi, lo, 1'b1, e, 3);
  endtask

  task automatic chk_outputs_zero(input string tag);
    chk({tag, "_cmd_valid"},   bus.cmd_valid,   0);
    chk({tag, "_cmd_channel"}, bus.cmd_channel, 0);
    chk({tag, "_cmd_pos_us"},  bus.cmd_pos_us,  0);
    chk({tag, "_cmd_clamped"}, bus.cmd_clamped, 0);
    chk({tag, "_frame_err"},   bus.frame_err,   0);
    chk({tag, "_err_code"},    bus.err_code,    0);
    chk({tag, "_busy"},        bus.busy,        0);
  endtask

  // Monitor: every strobe pops one expectation and is compared against it.
  always @(negedge clk) begin
    if (!rst && (bus.cmd_valid || bus.frame_err)) begin
      chk("strobes_exclusive", bus.cmd_valid & bus.frame_err, 0);
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_strobe: cmd_valid=%0d frame_err=%0d err_code=%0d, none expected (cycle %0d)",
                 bus.cmd_valid, bus.frame_err, bus.err_code, cyc);
      end else begin
        mon_e = exp_q.pop_front();
        chk("strobe_cycle", cyc, mon_e.at);
        if (mon_e.is_err) begin
          chk("frame_err", bus.frame_err, 1);
          chk("err_code",  bus.err_code,  mon_e.code);
        end else begin
          chk("cmd_valid",   bus.cmd_valid,   1);
          chk("cmd_channel", bus.cmd_channel, mon_e.ch);
          chk("cmd_pos_us",  bus.cmd_pos_us,  mon_e.pos);
          chk("cmd_clamped", bus.cmd_clamped, mon_e.clamped);
        end
      end
    end
  end

  initial begin
    exp_t e;
    e = '{1'b1, 0, 0, 0, 3, 0};
    rst        = 1'b1;
    bus.RxDone = 1'b0;
    bus.RxData = 8'h00;
    repeat (3) @(negedge clk);
    chk_outputs_zero("reset");
    rst = 1'b0;
    repeat (3) @(negedge clk);

    // Nominal, clamp-high, clamp-low, exact bounds, sync byte used as data.
    frame5(8'h01, 8'h05, 8'hDC, 8'hD8, 2, 2, 1'b0, 1, 1500, 0, 0);
    frame5(8'h02, 8'h0B, 8'hB8, 8'hB1, 2, 2, 1'b0, 2, 2500, 1, 0);
    frame5(8'h03, 8'h00, 8'h64, 8'h67, 2, 2, 1'b0, 3,  500, 1, 0);
    frame5(8'h00, 8'h09, 8'hC4, 8'hCD, 1, 1, 1'b0, 0, 2500, 0, 0);
    frame5(8'h01, 8'h01, 8'hF4, 8'hF4, 1, 1, 1'b0, 1,  500, 0, 0);
    frame5(8'h02, 8'hFF, 8'h00, 8'hFD, 2, 2, 1'b0, 2, 2500, 1, 0);

    // Checksum error: outputs from the last good frame must hold.
    frame5(8'h00, 8'h05, 8'hDC, 8'h00, 2, 2, 1'b1, 0, 0, 0, 2);
    repeat (4) @(negedge clk);
    chk("busy_after_csum_err", bus.busy,        0);
    chk("pos_hold",            bus.cmd_pos_us,  2500);
    chk("chan_hold",           bus.cmd_channel, 2);
    chk("clamped_hold",        bus.cmd_clamped, 1);

    // Bad channel.
    e = '{1'b1, 0, 0, 0, 1, 0};
    send_byte(8'hFF, 2, 2, 1'b0, e, 0);
    send_byte(8'h07, 2, 2, 1'b1, e, 3);
    repeat (4) @(negedge clk);
    chk("busy_after_chan_err", bus.busy, 0);

    // Leading junk, repeated sync, 40-cycle RxDone pulses.
    send_byte(8'h12, 40, 10, 1'b0, e, 0);
    send_byte(8'hFF, 40, 10, 1'b0, e, 0);
    frame5(8'h01, 8'h05, 8'hDC, 8'hD8, 40, 10, 1'b0, 1, 1500, 0, 0);
    repeat (4) @(negedge clk);
    chk("err_code_held", bus.err_code, 1);

    // Timeout: error strobe 100 cycles after the strobe of the 01 byte.
    e = '{1'b1, 0, 0, 0, 3, 0};
    send_byte(8'hFF, 2, 2, 1'b0, e, 0);
    chk("busy_in_frame", bus.busy, 1);
    send_byte(8'h01, 2, 2, 1'b1, e, 102);
    repeat (130) @(negedge clk);
    chk("busy_after_timeout", bus.busy, 0);
    frame5(8'h02, 8'h05, 8'hDC, 8'hDB, 2, 2, 1'b0, 2, 1500, 0, 0);

    // Reset mid-frame discards the partial frame.
    send_byte(8'hFF, 2, 2, 1'b0, e, 0);
    send_byte(8'h01, 2, 2, 1'b0, e, 0);
    send_byte(8'h05, 2, 2, 1'b0, e, 0);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    chk_outputs_zero("midreset");
    rst = 1'b0;
    send_byte(8'hDC, 2, 2, 1'b0, e, 0);
    send_byte(8'hD8, 2, 2, 1'b0, e, 0);
    repeat (4) @(negedge clk);
    chk("busy_after_orphan", bus.busy, 0);
    frame5(8'h01, 8'h05, 8'hDC, 8'hD8, 2, 2, 1'b0, 1, 1500, 0, 0);

    repeat (20) @(negedge clk);
    chk("expected_strobes_left", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/servo_cmd_parser.md
Name: servo_cmd_parser

Overview:
- Sits directly downstream of the UART byte receiver.
- Consumes each received byte (RxData qualified by RxDone) and assembles 5-byte servo command frames.
- Validates channel and checksum, and clamps the pulse width.
- Emits one registered command strobe per good frame to the servo PWM bank.

Parameters:
- NUM_CH, 4: number of servo channels; valid channel bytes are 0..NUM_CH-1.
- CH_W, 2: width of cmd_channel; must satisfy 2^CH_W >= NUM_CH.
- MIN_US, 500: lower clamp for pulse width, in microseconds.
- MAX_US, 2500: upper clamp for pulse width, in microseconds.
- TIMEOUT_CYC, 500000: allowed inter-byte gap in Clk cycles while a frame is in progress (10 ms at 50 MHz).
- SYNC_BYTE, 8'hFF: frame start marker.

Ports:
- Clk  in  1  system clock.
- Rst  in  1  asynchronous reset, active-high.
- RxData  in  8  received byte; stable while RxDone is high.
- RxDone  in  1  byte-complete flag from the receiver; a level of arbitrary length, not synchronous to the Clk edge.
- cmd_valid  out  1  one-cycle strobe: a good frame has been decoded.
- cmd_channel  out  CH_W  channel of the last good frame.
- cmd_pos_us  out  16  clamped pulse width of the last good frame.
- cmd_clamped  out  1  the last good frame was clamped; valid with cmd_valid.
- frame_err  out  1  one-cycle strobe: a frame was rejected.
- err_code  out  2  reason for the last rejection: 1 = bad channel, 2 = checksum, 3 = timeout. Valid with frame_err and held until the next error.
- busy  out  1  high whenever the state is not HUNT.

Behaviour:
- Clocking and reset: one clock domain, Clk. Rst is asynchronous, active-high.
- Reset values:
  - State = HUNT.
  - All outputs = 0, including cmd_channel, cmd_pos_us and err_code.
  - Checksum accumulator = 0; timeout counter = 0.
  - Reset mid-frame discards the partial frame; no strobe is generated.
- Byte acceptance:
  - RxDone passes through a 2-flop synchronizer, then a third flop; byte_stb = s2 & ~s3.
  - Cycle N = first Clk edge that samples RxDone high. byte_stb is high in cycle N+2, and RxData is captured in that cycle.
  - One byte is accepted per RxDone rising edge, regardless of the pulse length.
- Frame format: SYNC_BYTE, chan, pos_hi, pos_lo, csum. csum = chan ^ pos_hi ^ pos_lo.
- States (transitions occur only on byte_stb, except timeout):
  - HUNT: byte == SYNC_BYTE -> CHAN; any other byte is ignored.
  - CHAN:
    - byte == SYNC_BYTE -> stay in CHAN (resync, no error).
    - byte >= NUM_CH -> frame_err, err_code = 1, -> HUNT.
    - Otherwise latch chan, acc = byte, -> POSH.
  - POSH: latch pos_hi, acc ^= byte, -> POSL. SYNC_BYTE is data here.
  - POSL: latch pos_lo, acc ^= byte, -> CSUM. SYNC_BYTE is data here.
  - CSUM:
    - byte == acc -> good frame, -> HUNT.
    - Otherwise frame_err, err_code = 2, -> HUNT.
- Good frame:
  - pos = {pos_hi, pos_lo}, unsigned.
  - pos < MIN_US -> MIN_US, cmd_clamped = 1.
  - pos > MAX_US -> MAX_US, cmd_clamped = 1.
  - Otherwise pos passes through unchanged, cmd_clamped = 0.
  - cmd_channel, cmd_pos_us and cmd_clamped update in the cycle after byte_stb; cmd_valid is high for exactly that cycle.
  - Total latency from cycle N (CSUM byte) to cmd_valid is 3 cycles (cmd_valid high in cycle N+3).
  - cmd_* hold their values until the next good frame.
- Error strobe timing: frame_err is high for one cycle, in the cycle after the offending byte_stb or after the timeout expires. err_code updates in the same cycle.
- Timeout:
  - The counter clears on every byte_stb and while in HUNT, and increments otherwise.
  - On reaching TIMEOUT_CYC-1: frame_err, err_code = 3, -> HUNT, counter clears.
  - If byte_stb and timeout expiry occur in the same cycle, the byte wins and no timeout is reported.
- Back-to-back frames with zero gap are supported; the HUNT to CHAN transition has no dead cycle.
- cmd_valid and frame_err are never high in the same cycle.

Test Plan:
- Bytes FF 01 05 DC D8 -> one cmd_valid, cmd_channel = 1, cmd_pos_us = 1500, cmd_clamped = 0, 3 cycles after the last RxDone edge is sampled.
- Bytes FF 02 0B B8 B1 (3000 us) -> cmd_valid, cmd_pos_us = 2500, cmd_clamped = 1. Bytes FF 03 00 64 67 (100 us) -> cmd_pos_us = 500, cmd_clamped = 1.
- Bytes FF 00 05 DC 00 -> frame_err, err_code = 2, no cmd_valid, busy = 0 afterwards. Bytes FF 07 (NUM_CH = 4) -> frame_err, err_code = 1.
- Bytes 12 FF FF 01 05 DC D8, with RxDone held high 40 cycles per byte -> a single cmd_valid with channel 1 and 1500 us; each long RxDone pulse counts as one byte.
- TIMEOUT_CYC = 100; bytes FF 01, then idle -> frame_err, err_code = 3, exactly 100 cycles after the 01 byte_stb. Then a full good frame decodes normally.
- Rst asserted after FF 01 05, then released, then DC D8 -> no strobes. A following FF 01 05 DC D8 -> cmd_valid. All outputs read 0 during Rst.
